// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard frame receiver with E0/F0 prefix folding
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] keycode,
  output logic       key_make,
  output logic       key_ext,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, RECV} state_t;

  logic [1:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic          filt_q;
  logic [FW-1:0] filt_cnt_q;
  logic          fall_w;
  logic          dat_w;

  state_t        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [8:0]    shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_pend_q, ext_pend_d;
  logic          brk_pend_q, brk_pend_d;
  logic [7:0]    keycode_q, keycode_d;
  logic          make_q, make_d;
  logic          ext_q, ext_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  // Two-flop synchronisers; idle line level is high, so reset to 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_dat};
    end
  end

  // Glitch filter: the filtered clock follows only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else if (clk_sync_q[1] == filt_q) begin
      filt_cnt_q <= '0;
    end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
      filt_q     <= clk_sync_q[1];
      filt_cnt_q <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_q + 1'b1;
    end
  end

  // The falling edge is the cycle on which the filter is about to flip from 1 to 0.
  assign fall_w = filt_q & ~clk_sync_q[1] & (filt_cnt_q == FW'(FILTER_LEN - 1));
  assign dat_w  = dat_sync_q[1];

  // State, frame and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tmo_q      <= '0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      keycode_q  <= 8'h00;
      make_q     <= 1'b0;
      ext_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tmo_q      <= tmo_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      keycode_q  <= keycode_d;
      make_q     <= make_d;
      ext_q      <= ext_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  // Frame FSM: shift in data+parity, validate at the stop bit, fold prefixes into flags.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tmo_d      = tmo_q;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    keycode_d  = keycode_q;
    make_d     = make_q;
    ext_d      = ext_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (fall_w && !dat_w) begin
          state_d   = RECV;
          bit_cnt_d = '0;
        end
      end
      RECV: begin
        if (fall_w) begin
          tmo_d = '0;
          if (bit_cnt_q == 4'd9) begin
            state_d = IDLE;
            // shift_q holds 8 data bits plus parity; odd total ones and stop = 1 is good.
            if ((^shift_q) && dat_w) begin
              if (shift_q[7:0] == 8'hE0) begin
                ext_pend_d = 1'b1;
              end else if (shift_q[7:0] == 8'hF0) begin
                brk_pend_d = 1'b1;
              end else begin
                keycode_d  = shift_q[7:0];
                make_d     = !brk_pend_q;
                ext_d      = ext_pend_q;
                valid_d    = 1'b1;
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
              end
            end else begin
              err_d      = 1'b1;
              ext_pend_d = 1'b0;
              brk_pend_d = 1'b0;
            end
          end else begin
            shift_d   = {dat_w, shift_q[8:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
          state_d    = IDLE;
          tmo_d      = '0;
          err_d      = 1'b1;
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign keycode   = keycode_q;
  assign key_make  = make_q;
  assign key_ext   = ext_q;
  assign key_valid = valid_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - scoreboard bench for ps2_key_decoder
module tb_ps2_key_decoder;

  localparam int FL  = 8;
  localparam int TMO = 3000;
  localparam int HB  = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] keycode;
  logic       key_make;
  logic       key_ext;
  logic       key_valid;
  logic       frame_err;

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .keycode   (keycode),
    .key_make  (key_make),
    .key_ext   (key_ext),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit         is_err;
    bit         lat;
    logic [7:0] code;
    bit         make;
    bit         ext;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  bit         ext_m = 0, brk_m = 0;
  logic [7:0] code_m = 8'h00;
  bit         make_m = 0, ext_h = 0;
  int         last_stop = 0;
  bit         mon_en = 0;
  bit         prev_s = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: one call per frame as seen by the keyboard protocol.
  task automatic model_frame(logic [7:0] b, bit good, bit lat);
    exp_t e;
    if (!good) begin
      e = '{1'b1, lat, code_m, make_m, ext_h};
      sb.push_back(e);
      ext_m = 0;
      brk_m = 0;
    end else if (b == 8'hE0) begin
      ext_m = 1;
    end else if (b == 8'hF0) begin
      brk_m = 1;
    end else begin
      code_m = b;
      make_m = !brk_m;
      ext_h  = ext_m;
      e = '{1'b0, 1'b1, code_m, make_m, ext_h};
      sb.push_back(e);
      ext_m = 0;
      brk_m = 0;
    end
  endtask

  task automatic send_frame(logic [7:0] b, bit bad_par, bit bad_stop, int nbits);
    logic [10:0] f;
    f[0]    = 1'b0;
    f[8:1]  = b;
    f[9]    = (~^b) ^ bad_par;
    f[10]   = !bad_stop;
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      tick(HB);
      ps2_clk = 1'b0;
      if (i == 10) last_stop = cyc;
      tick(HB);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    tick(HB);
  endtask

  task automatic full(logic [7:0] b, bit bp, bit bs);
    model_frame(b, !(bp || bs), 1'b1);
    send_frame(b, bp, bs, 11);
    tick(20);
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes.
  always @(negedge clk) begin : mon
    exp_t e;
    int   lat;
    bit   s;
    s = key_valid | frame_err;
    if (mon_en && s) begin
      check("valid_err_exclusive", key_valid & frame_err, 0);
      check("strobe_width", prev_s, 0);
      if (sb.size() == 0) begin
        check("unexpected_strobe", {key_valid, frame_err}, 0);
      end else begin
        e = sb.pop_front();
        check("strobe_kind", frame_err, e.is_err);
        check("keycode", keycode, e.code);
        check("key_make", key_make, e.make);
        check("key_ext", key_ext, e.ext);
        if (e.lat) begin
          lat = cyc - last_stop;
          checks++;
          if (lat < FL + 1 || lat > FL + 4) begin
            failures++;
            $display("FAIL strobe_latency actual=%0d expected=%0d..%0d", lat, FL + 1, FL + 4);
          end
        end
      end
    end
    prev_s = s;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    tick(3);
    check("rst_keycode", keycode, 8'h00);
    check("rst_make", key_make, 0);
    check("rst_ext", key_ext, 0);
    check("rst_valid", key_valid, 0);
    check("rst_err", frame_err, 0);
    reset = 1'b1;
    tick(2);
    mon_en = 1;

    // Make, break, extended make/break, then flags cleared.
    full(8'h1C, 0, 0);
    full(8'hF0, 0, 0);
    full(8'h1C, 0, 0);
    full(8'hE0, 0, 0);
    full(8'h75, 0, 0);
    full(8'hE0, 0, 0);
    full(8'hF0, 0, 0);
    full(8'h75, 0, 0);
    full(8'h1C, 0, 0);

    // Parity error then a good frame.
    full(8'h1C, 1, 0);
    full(8'h29, 0, 0);

    // Timeout clears a pending E0.
    full(8'hE0, 0, 0);
    model_frame(8'h00, 1'b0, 1'b0);
    send_frame(8'h5A, 0, 0, 5);
    tick(TMO + 60);
    full(8'h75, 0, 0);

    // Reset mid-frame with E0 pending.
    full(8'hE0, 0, 0);
    send_frame(8'h1C, 0, 0, 4);
    reset = 1'b0;
    #1;
    check("midrst_keycode", keycode, 8'h00);
    check("midrst_make", key_make, 0);
    check("midrst_ext", key_ext, 0);
    check("midrst_valid", key_valid, 0);
    check("midrst_err", frame_err, 0);
    ext_m = 0; brk_m = 0; code_m = 8'h00; make_m = 0; ext_h = 0;
    tick(5);
    reset = 1'b1;
    tick(5);
    full(8'h1C, 0, 0);

    // Short clock glitch with data low must not start a frame.
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(30);
    ps2_dat = 1'b1;
    tick(5);
    full(8'h1C, 0, 0);

    // Randomised traffic with prefixes and occasional errors.
    for (int n = 0; n < 50; n++) begin
      int         r;
      logic [7:0] b;
      bit         bp, bs;
      r  = $urandom_range(0, 9);
      b  = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 9) == 0);
      bs = !bp && ($urandom_range(0, 19) == 0);
      full(b, bp, bs);
    end

    for (int i = 0; i < 200 && sb.size() != 0; i++) tick(1);
    check("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives PS/2 keyboard frames on the raw PS/2 clock/data lines and produces the `keycode` / `key_make` / `key_ext` event interface consumed by the game processor. It sits between the board PS/2 pins and the processor. It synchronises and filters the PS/2 lines, deserialises 11-bit frames, and checks parity and stop bits. It folds the `E0` (extended) and `F0` (break) prefix bytes into flags on the following scan code.

## Interface
- `FILTER_LEN`, 8: consecutive equal `clk` samples required before the filtered PS/2 clock changes level.
- `TIMEOUT_CYCLES`, 50000: `clk` cycles allowed between PS/2 falling edges inside a frame (1 ms at 50 MHz).
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_dat`  in  1  raw PS/2 data pin, asynchronous.
- `keycode`  out  8  last decoded scan code, held until the next event.
- `key_make`  out  1  1 = press (make), 0 = release (break) for `keycode`; held.
- `key_ext`  out  1  1 = code was preceded by `E0`; held.
- `key_valid`  out  1  one-cycle strobe; `keycode`/`key_make`/`key_ext` updated this cycle.
- `frame_err`  out  1  one-cycle strobe on a parity, stop-bit or timeout error.

## Operation
- Input conditioning
  - `ps2_clk` and `ps2_dat` each pass through a 2-flop synchroniser.
  - Filtered clock: changes to the synchronised level only after `FILTER_LEN` consecutive identical samples.
  - Falling edge: filtered clock goes from 1 to 0. The synchronised `ps2_dat` is sampled on that cycle.
- Frame format: start bit (0), then 8 data bits LSB first, then odd parity, then stop bit (1).
- FSM states: IDLE and RECV.
  - IDLE: on a falling edge with data = 0, go to RECV with bit count = 0. A falling edge with data = 1 is ignored.
  - RECV: each falling edge shifts one bit in and increments the count (data bits 0–7, parity, stop).
  - On the stop-bit edge, check that the count of ones in data + parity is odd and that stop = 1, then return to IDLE.
- Byte handling on a good frame:
  - `E0`: set `ext_pend`; no strobe.
  - `F0`: set `brk_pend`; no strobe.
  - Any other byte: `keycode` = byte, `key_make` = !`brk_pend`, `key_ext` = `ext_pend`, assert `key_valid`, then clear both pending flags.
  - `E1`, `AA`, `FA` and similar bytes are forwarded as ordinary codes.
- Errors: bad parity, stop = 0, or timeout.
  - Discard the byte, pulse `frame_err`, clear `ext_pend` and `brk_pend`, return to IDLE.
  - Held outputs are unchanged.
- Timeout: the counter runs only in RECV and clears on every falling edge. It fires when it reaches `TIMEOUT_CYCLES`.

## Timing
- Reset values: `keycode` = 0x00, `key_make` = 0, `key_ext` = 0, `key_valid` = 0, `frame_err` = 0. State = IDLE, pending flags clear, filter and synchronisers = 1 (idle line level).
- `key_valid` and `frame_err` are registered. They assert on the clock edge after the stop-bit falling edge is detected, for exactly 1 cycle.
- Pin to detected edge: 2 synchroniser cycles + `FILTER_LEN` cycles.
- Timeout `frame_err`: asserted on the cycle after the counter reaches `TIMEOUT_CYCLES`. The FSM is in IDLE on that same cycle.
- `key_valid` and `frame_err` never assert together.
- Pending flags persist across IDLE for any time; only a non-prefix byte, an error or reset clears them.
- Reset mid-frame: the partial frame is discarded. After release, the next start bit begins a fresh frame.
- Glitches on `ps2_clk` shorter than `FILTER_LEN` cycles produce no edge.

## Test plan
- Frame 0x1C (bits 0,00111000,0,1) → 1 cycle after stop edge: `keycode` = 0x1C, `key_make` = 1, `key_ext` = 0, `key_valid` high exactly 1 cycle.
- Frames F0 then 1C → one strobe only, with `keycode` = 0x1C, `key_make` = 0, `key_ext` = 0. The F0 frame produces no strobe.
- Frames E0 75, then E0 F0 75 → first strobe 0x75 / make 1 / ext 1; second strobe 0x75 / make 0 / ext 1. Flags are clear afterwards, so a following 0x1C gives ext 0.
- 0x1C sent with parity = 1 → `frame_err` 1-cycle pulse, no `key_valid`, outputs hold their prior values. The next good 0x29 decodes normally.
- E0, then a frame stopped after 5 bits, idle for `TIMEOUT_CYCLES` + 10 → one `frame_err` pulse. A following 0x75 decodes with `key_ext` = 0, since the prefix was cleared by the error.
- `reset` = 0 asserted mid-frame after 4 bits → all outputs return to reset values immediately. After release, a full 0x1C frame decodes correctly. A 3-cycle `ps2_clk` glitch produces no edge.
